// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, program-memory request handshake and IR.
// Optional fetch watchdog with sticky FetchErr enabled by `define FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int                     PC_WIDTH       = 8,
    parameter int                     INSTR_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR   = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_OPCODE     = '0,
    parameter int                     TIMEOUT_CYCLES = 15
) (
    input  logic                   CLK,
    input  logic                   CLB,
    input  logic                   LoadIR,
    input  logic                   IncPC,
    input  logic                   LoadPC,
    input  logic                   SelPC,
    input  logic [PC_WIDTH-1:0]    RegData,
    input  logic [PC_WIDTH-1:0]    ImmData,
    output logic [PC_WIDTH-1:0]    MemAddr,
    output logic                   MemReq,
    input  logic                   MemAck,
    input  logic [INSTR_WIDTH-1:0] MemData,
    output logic [INSTR_WIDTH-1:0] Opcode,
    output logic                   OpValid,
    output logic [PC_WIDTH-1:0]    PC,
`ifdef FETCH_TIMEOUT_EN
    output logic                   FetchErr,
`endif
    output logic                   Busy
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_FETCH = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic                   state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   opv_q, opv_d;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH-1:0]    pc_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [WD_W-1:0] wdog_inc;
    logic            err_q, err_d;

    assign wdog_inc = wdog_q + WD_W'(1);
`endif

    assign pc_inc = pc_q + PC_WIDTH'(1);

    always_comb begin
        pc_next = pc_q;
        if (LoadPC) begin
            pc_next = SelPC ? ImmData : RegData;
        end else if (IncPC) begin
            pc_next = pc_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        busy_d  = busy_q;
        ir_d    = ir_q;
        opv_d   = opv_q;
`ifdef FETCH_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Address follows next-PC so a same-cycle jump or
                // increment is what gets fetched.
                pc_d   = pc_next;
                addr_d = pc_next;
                if (LoadIR) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    opv_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            S_FETCH: begin
                if (MemAck) begin
                    state_d = S_IDLE;
                    ir_d    = MemData;
                    opv_d   = 1'b1;
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                end else if (wdog_inc == WD_W'(TIMEOUT_CYCLES)) begin
                    // Abort: hand the controller a NOP, leave PC alone.
                    state_d = S_IDLE;
                    ir_d    = NOP_OPCODE;
                    opv_d   = 1'b1;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_inc;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ir_q    <= NOP_OPCODE;
            opv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            ir_q    <= ir_d;
            opv_q   <= opv_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign FetchErr = err_q;
`endif

    assign MemAddr = addr_q;
    assign MemReq  = req_q;
    assign Busy    = busy_q;
    assign Opcode  = ir_q;
    assign OpValid = opv_q;
    assign PC      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a latency-programmable program memory.
// Covers the FETCH_TIMEOUT_EN build when that macro is defined.
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       CLB = 1'b0;
    logic       LoadIR = 1'b0;
    logic       IncPC = 1'b0;
    logic       LoadPC = 1'b0;
    logic       SelPC = 1'b0;
    logic [7:0] RegData = '0;
    logic [7:0] ImmData = '0;
    logic       MemAck = 1'b0;
    logic [7:0] MemData = '0;
    logic [7:0] MemAddr;
    logic       MemReq;
    logic [7:0] Opcode;
    logic       OpValid;
    logic [7:0] PC;
    logic       Busy;
`ifdef FETCH_TIMEOUT_EN
    logic       FetchErr;
`endif

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] pc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] mem[256];
    int         ack_delay = 0;
    bit         mem_en = 1'b1;
    bit         force_ack = 1'b0;
    int         wait_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .PC_WIDTH(8),
        .INSTR_WIDTH(8),
        .RESET_VECTOR(8'h00),
        .NOP_OPCODE(8'h00),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .CLK(CLK),
        .CLB(CLB),
        .LoadIR(LoadIR),
        .IncPC(IncPC),
        .LoadPC(LoadPC),
        .SelPC(SelPC),
        .RegData(RegData),
        .ImmData(ImmData),
        .MemAddr(MemAddr),
        .MemReq(MemReq),
        .MemAck(MemAck),
        .MemData(MemData),
        .Opcode(Opcode),
        .OpValid(OpValid),
        .PC(PC),
`ifdef FETCH_TIMEOUT_EN
        .FetchErr(FetchErr),
`endif
        .Busy(Busy)
    );

    // Program memory: acks ack_delay cycles after MemReq is first seen.
    always @(posedge CLK) begin
        #2;
        if (force_ack) begin
            MemAck = 1'b1;
            MemData = 8'hEE;
        end else if (mem_en && MemReq) begin
            if (wait_cnt >= ack_delay) begin
                MemAck = 1'b1;
                MemData = mem[MemAddr];
                wait_cnt = 0;
            end else begin
                MemAck = 1'b0;
                wait_cnt++;
            end
        end else begin
            MemAck = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_op(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
            LoadIR = 1'b0;
        end while (!OpValid && cyc < max);
    endtask

    task automatic test_reset();
        CLB = 1'b0;
        tick();
        n_tests++; if (PC !== 8'h00) begin n_fail++; $display("FAIL rst_pc got %h exp 00", PC); end
        n_tests++; if (MemAddr !== 8'h00) begin n_fail++; $display("FAIL rst_addr got %h exp 00", MemAddr); end
        n_tests++; if (Opcode !== 8'h00) begin n_fail++; $display("FAIL rst_op got %h exp 00", Opcode); end
        n_tests++; if (OpValid !== 1'b0) begin n_fail++; $display("FAIL rst_opv got %b exp 0", OpValid); end
        n_tests++; if (MemReq !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", MemReq); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", Busy); end
`ifdef FETCH_TIMEOUT_EN
        n_tests++; if (FetchErr !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", FetchErr); end
`endif
        CLB = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        ack_delay = 0;
        LoadIR = 1'b1;
        sb.push_back(exp_t'{op: mem[8'h00], pc: 8'h01});
        tick();
        LoadIR = 1'b0;
        n_tests++; if (MemReq !== 1'b1) begin n_fail++; $display("FAIL b_req got %b exp 1", MemReq); end
        n_tests++; if (MemAddr !== 8'h00) begin n_fail++; $display("FAIL b_addr got %h exp 00", MemAddr); end
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b_busy got %b exp 1", Busy); end
        n_tests++; if (OpValid !== 1'b0) begin n_fail++; $display("FAIL b_opv0 got %b exp 0", OpValid); end
        tick();
        n_tests++; if (OpValid !== 1'b1) begin n_fail++; $display("FAIL b_opv got %b exp 1", OpValid); end
        n_tests++; if (MemReq !== 1'b0) begin n_fail++; $display("FAIL b_req1 got %b exp 0", MemReq); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b_busy1 got %b exp 0", Busy); end
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (Opcode !== e.op || PC !== e.pc) begin
                n_fail++; $display("FAIL b_data got %h/%h exp %h/%h", Opcode, PC, e.op, e.pc);
            end
        end
    endtask

    task automatic test_loadpc_fetch();
        int cyc;
        LoadPC = 1'b1; SelPC = 1'b1; ImmData = 8'h40;
        tick();
        LoadPC = 1'b0;
        n_tests++; if (PC !== 8'h40) begin n_fail++; $display("FAIL j_pc40 got %h exp 40", PC); end
        ack_delay = 1;
        LoadPC = 1'b1; SelPC = 1'b0; RegData = 8'h9A; LoadIR = 1'b1;
        sb.push_back(exp_t'{op: mem[8'h9A], pc: 8'h9B});
        tick();
        LoadPC = 1'b0; LoadIR = 1'b0;
        n_tests++; if (MemAddr !== 8'h9A) begin n_fail++; $display("FAIL j_addr got %h exp 9a", MemAddr); end
        n_tests++; if (MemReq !== 1'b1) begin n_fail++; $display("FAIL j_req got %b exp 1", MemReq); end
        wait_op(20, cyc);
        n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL j_lat got %0d exp 2", cyc); end
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL j_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (Opcode !== e.op || PC !== e.pc) begin
                n_fail++; $display("FAIL j_data got %h/%h exp %h/%h", Opcode, PC, e.op, e.pc);
            end
        end
    endtask

    task automatic test_pc_priority();
        LoadPC = 1'b1; IncPC = 1'b1; SelPC = 1'b1; ImmData = 8'h05;
        tick();
        n_tests++; if (PC !== 8'h05) begin n_fail++; $display("FAIL p_prio got %h exp 05", PC); end
        n_tests++; if (MemAddr !== 8'h05) begin n_fail++; $display("FAIL p_addr got %h exp 05", MemAddr); end
        IncPC = 1'b0; ImmData = 8'hFF;
        tick();
        LoadPC = 1'b0; IncPC = 1'b1;
        tick();
        IncPC = 1'b0;
        n_tests++; if (PC !== 8'h00) begin n_fail++; $display("FAIL p_wrap got %h exp 00", PC); end
        ack_delay = 0;
        IncPC = 1'b1; LoadIR = 1'b1;
        sb.push_back(exp_t'{op: mem[8'h01], pc: 8'h02});
        tick();
        IncPC = 1'b0; LoadIR = 1'b0;
        n_tests++; if (MemAddr !== 8'h01) begin n_fail++; $display("FAIL p_incaddr got %h exp 01", MemAddr); end
        tick();
        n_tests++;
        if (!OpValid || sb.size() == 0) begin n_fail++; $display("FAIL p_done got opv=%b exp 1", OpValid); end
        else begin
            e = sb.pop_front();
            if (Opcode !== e.op || PC !== e.pc) begin
                n_fail++; $display("FAIL p_data got %h/%h exp %h/%h", Opcode, PC, e.op, e.pc);
            end
        end
    endtask

    task automatic test_wait_state();
        int iter;
        ack_delay = 4;
        LoadIR = 1'b1;
        sb.push_back(exp_t'{op: mem[8'h02], pc: 8'h03});
        tick();
        LoadIR = 1'b0;
        iter = 0;
        while (!OpValid && iter < 20) begin
            n_tests++;
            if (MemReq !== 1'b1 || Busy !== 1'b1 || MemAddr !== 8'h02 || PC !== 8'h02) begin
                n_fail++;
                $display("FAIL w_hold got req=%b busy=%b addr=%h pc=%h exp 1/1/02/02", MemReq, Busy, MemAddr, PC);
            end
            IncPC = iter[0]; LoadPC = ~iter[0]; SelPC = 1'b1; ImmData = 8'hC3;
            tick();
            iter++;
        end
        IncPC = 1'b0; LoadPC = 1'b0;
        n_tests++; if (iter !== 5) begin n_fail++; $display("FAIL w_lat got %0d exp 5", iter); end
        n_tests++;
        if (!OpValid || sb.size() == 0) begin n_fail++; $display("FAIL w_done got opv=%b exp 1", OpValid); end
        else begin
            e = sb.pop_front();
            if (Opcode !== e.op || PC !== e.pc) begin
                n_fail++; $display("FAIL w_data got %h/%h exp %h/%h", Opcode, PC, e.op, e.pc);
            end
        end
    endtask

    task automatic test_idle_ack();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        n_tests++; if (Opcode !== mem[8'h02]) begin n_fail++; $display("FAIL i_op got %h exp %h", Opcode, mem[8'h02]); end
        n_tests++; if (OpValid !== 1'b1 || PC !== 8'h03) begin n_fail++; $display("FAIL i_state got %b/%h exp 1/03", OpValid, PC); end
    endtask

    task automatic test_reset_mid_fetch();
        ack_delay = 8;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        tick();
        n_tests++; if (MemReq !== 1'b1) begin n_fail++; $display("FAIL r_req got %b exp 1", MemReq); end
        #2 CLB = 1'b0;
        #1;
        n_tests++;
        if (MemReq !== 1'b0 || Busy !== 1'b0 || OpValid !== 1'b0) begin
            n_fail++; $display("FAIL r_async got req=%b busy=%b opv=%b exp 0/0/0", MemReq, Busy, OpValid);
        end
        n_tests++;
        if (PC !== 8'h00 || Opcode !== 8'h00 || MemAddr !== 8'h00) begin
            n_fail++; $display("FAIL r_vals got %h/%h/%h exp 00/00/00", PC, Opcode, MemAddr);
        end
        tick();
        CLB = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        tick();
        n_tests++;
        if (Opcode !== 8'h00 || OpValid !== 1'b0 || MemReq !== 1'b0 || PC !== 8'h00) begin
            n_fail++; $display("FAIL r_late got %h/%b/%b/%h exp 00/0/0/00", Opcode, OpValid, MemReq, PC);
        end
    endtask

    task automatic test_back_to_back();
        ack_delay = 0;
        for (int k = 0; k < 4; k++) begin
            LoadIR = 1'b1;
            sb.push_back(exp_t'{op: mem[k], pc: 8'(k + 1)});
            tick();
            LoadIR = 1'b0;
            tick();
            n_tests++;
            if (!OpValid || sb.size() == 0) begin n_fail++; $display("FAIL bb_done%0d got opv=%b exp 1", k, OpValid); end
            else begin
                e = sb.pop_front();
                if (Opcode !== e.op || PC !== e.pc) begin
                    n_fail++; $display("FAIL bb_data%0d got %h/%h exp %h/%h", k, Opcode, PC, e.op, e.pc);
                end
            end
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        mem_en = 1'b0;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        wait_op(40, cyc);
        n_tests++; if (cyc !== 15) begin n_fail++; $display("FAIL t_lat got %0d exp 15", cyc); end
        n_tests++;
        if (Opcode !== 8'h00 || OpValid !== 1'b1 || FetchErr !== 1'b1) begin
            n_fail++; $display("FAIL t_abort got %h/%b/%b exp 00/1/1", Opcode, OpValid, FetchErr);
        end
        n_tests++; if (PC !== 8'h04 || MemReq !== 1'b0) begin n_fail++; $display("FAIL t_pc got %h/%b exp 04/0", PC, MemReq); end
        mem_en = 1'b1;
        ack_delay = 0;
        LoadIR = 1'b1;
        sb.push_back(exp_t'{op: mem[8'h04], pc: 8'h05});
        tick();
        LoadIR = 1'b0;
        tick();
        n_tests++;
        if (!OpValid || sb.size() == 0) begin n_fail++; $display("FAIL t_next got opv=%b exp 1", OpValid); end
        else begin
            e = sb.pop_front();
            if (Opcode !== e.op || PC !== e.pc) begin
                n_fail++; $display("FAIL t_data got %h/%h exp %h/%h", Opcode, PC, e.op, e.pc);
            end
        end
        n_tests++; if (FetchErr !== 1'b1) begin n_fail++; $display("FAIL t_sticky got %b exp 1", FetchErr); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h12;
        tick();
        test_reset();
        test_basic_fetch();
        test_loadpc_fetch();
        test_pc_priority();
        test_wait_state();
        test_idle_ack();
        test_reset_mid_fetch();
        test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_left got %0d exp 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
